// File: rtl/unibus_mem_responder.sv
// unibus_mem_responder
//   Byte-wide memory target for the AY8 core memory interface. Serves
//   instruction fetches and data reads with a fixed read latency
//   (RD_LATENCY edges from accept to rsp_valid sampled high), and performs
//   single-cycle writes. A side-band loader port preloads program images
//   into the array in any state.
//
//   Optional feature macro: UNIBUS_MEM_WRITE_ACK_EN
//     defined   - accepted writes also produce a one-cycle rsp_valid pulse
//                 carrying the written data (one write per 2 cycles).
//     undefined - writes complete silently, one per cycle.
//
// Ports
//   CLK        clock, all state updates on rising edge
//   RST        synchronous reset, active-high (memory contents kept)
//   req_valid  initiator presents a request
//   req_write  1 = write, 0 = read
//   req_addr   request address
//   req_wdata  write data
//   req_ready  responder can accept (combinational)
//   rsp_valid  read data valid, one-cycle pulse, no backpressure
//   rsp_rdata  read data, meaningful only while rsp_valid is high
//   ld_en      loader write strobe (blocks request acceptance)
//   ld_addr    loader address
//   ld_data    loader data
module unibus_mem_responder #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              req_in_range;
    logic              ld_in_range;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  ld_idx;

    always_comb begin
        req_ready    = (state == IDLE) && !ld_en && !RST;
        accept       = req_valid && req_ready;
        rd_acc       = accept && !req_write;
        wr_acc       = accept && req_write;
        req_in_range = ({1'b0, req_addr} < DEPTH_L);
        ld_in_range  = ({1'b0, ld_addr} < DEPTH_L);
        req_idx      = req_addr[IDX_W-1:0];
        ld_idx       = ld_addr[IDX_W-1:0];
    end

    // Next-state logic; cnt holds the remaining WAIT cycles minus one.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (rd_acc) begin
                    if (RD_LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
`ifdef UNIBUS_MEM_WRITE_ACK_EN
                else if (wr_acc) begin
                    state_nxt = RESP;
                end
`endif
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read data is captured at the accept edge so later writes or loads
    // to the same word cannot disturb the pending response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (rd_acc) begin
                hold <= req_in_range ? mem[req_idx] : '0;
            end
`ifdef UNIBUS_MEM_WRITE_ACK_EN
            else if (wr_acc) begin
                hold <= req_wdata;
            end
`endif
        end
    end

    // Loader and request writes are mutually exclusive because ld_en
    // holds req_ready low; out-of-range writes are dropped.
    always_ff @(posedge CLK) begin
        if (ld_en && ld_in_range) begin
            mem[ld_idx] <= ld_data;
        end else if (wr_acc && req_in_range) begin
            mem[req_idx] <= req_wdata;
        end
    end

    always_comb begin
        rsp_valid = (state == RESP);
        rsp_rdata = hold;
    end

endmodule

// File: tb/tb_unibus_mem_responder.sv
// tb_unibus_mem_responder
//   Self-checking bench for unibus_mem_responder. Two instances are
//   exercised: k=0 (DEPTH 256, RD_LATENCY 1) and k=1 (DEPTH 128,
//   RD_LATENCY 3). A per-instance byte-array reference model predicts
//   read data, latency and write acknowledgement.
module tb_unibus_mem_responder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_write = '0;
    logic [1:0] ld_en     = '0;
    logic [7:0] req_addr  [2] = '{8'h00, 8'h00};
    logic [7:0] req_wdata [2] = '{8'h00, 8'h00};
    logic [7:0] ld_addr   [2] = '{8'h00, 8'h00};
    logic [7:0] ld_data   [2] = '{8'h00, 8'h00};
    logic       req_ready [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_rdata [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [2][256];

    always #5 CLK = ~CLK;

    unibus_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .RD_LATENCY(1)) dut0 (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0])
    );

    unibus_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .RD_LATENCY(3)) dut1 (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1])
    );

    function automatic int dep(input int k);
        return (k == 0) ? 256 : 128;
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] exp_rd(input int k, input logic [7:0] a);
        return (int'(a) < dep(k)) ? mdl[k][a] : 8'h00;
    endfunction

    function automatic void mdl_wr(input int k, input logic [7:0] a, input logic [7:0] d);
        if (int'(a) < dep(k)) mdl[k][a] = d;
    endfunction

    // All tasks start and end on a falling edge.
    task automatic ld(input int k, input logic [7:0] a, input logic [7:0] d);
        ld_en[k] = 1'b1; ld_addr[k] = a; ld_data[k] = d;
        @(negedge CLK);
        mdl_wr(k, a, d);
        ld_en[k] = 1'b0;
    endtask

    task automatic wr(input int k, input logic [7:0] a, input logic [7:0] d, output time t_acc);
        int waited;
        req_valid[k] = 1'b1; req_write[k] = 1'b1; req_addr[k] = a; req_wdata[k] = d;
        waited = 0;
        #1;
        while (!req_ready[k] && waited < 10) begin
            @(negedge CLK); #1; waited++;
        end
        checks++;
        if (req_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL wr_ready_timeout k=%0d got %b exp 1", k, req_ready[k]);
        end
        @(posedge CLK);
        t_acc = $time;
        mdl_wr(k, a, d);
        @(negedge CLK);
        req_valid[k] = 1'b0;
`ifdef UNIBUS_MEM_WRITE_ACK_EN
        checks++;
        if (rsp_valid[k] !== 1'b1 || rsp_rdata[k] !== d) begin
            errors++;
            $display("FAIL wr_ack k=%0d got valid=%b data=%h exp valid=1 data=%h", k, rsp_valid[k], rsp_rdata[k], d);
        end
        @(negedge CLK);
`else
        checks++;
        if (rsp_valid[k] !== 1'b0) begin
            errors++;
            $display("FAIL wr_no_rsp k=%0d got %b exp 0", k, rsp_valid[k]);
        end
`endif
    endtask

    // Read with optional loader write issued on the first cycle after accept.
    task automatic rd(input int k, input logic [7:0] a, input bit mid_ld,
                      input logic [7:0] la, input logic [7:0] ldd);
        logic [7:0] exp;
        int  waited;
        int  n;
        bit  seen;
        req_valid[k] = 1'b1; req_write[k] = 1'b0; req_addr[k] = a;
        waited = 0;
        #1;
        while (!req_ready[k] && waited < 10) begin
            @(negedge CLK); #1; waited++;
        end
        checks++;
        if (req_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL rd_ready_timeout k=%0d got %b exp 1", k, req_ready[k]);
        end
        @(posedge CLK);
        exp = exp_rd(k, a);
        @(negedge CLK);
        req_valid[k] = 1'b0;
        seen = 1'b0;
        for (n = 1; n <= 20; n++) begin
            if (ld_en[k]) begin
                ld_en[k] = 1'b0;
                mdl_wr(k, la, ldd);
            end
            if (n == 1 && mid_ld) begin
                ld_en[k] = 1'b1; ld_addr[k] = la; ld_data[k] = ldd;
            end
            checks++;
            if (req_ready[k] !== 1'b0) begin
                errors++;
                $display("FAIL rd_busy_ready k=%0d n=%0d got %b exp 0", k, n, req_ready[k]);
            end
            if (rsp_valid[k] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rd_timeout k=%0d addr=%h got no rsp_valid exp latency %0d", k, a, lat(k));
        end else begin
            if (n != lat(k)) begin
                errors++;
                $display("FAIL rd_latency k=%0d addr=%h got %0d exp %0d", k, a, n, lat(k));
            end
            checks++;
            if (rsp_rdata[k] !== exp) begin
                errors++;
                $display("FAIL rd_data k=%0d addr=%h got %h exp %h", k, a, rsp_rdata[k], exp);
            end
        end
        @(negedge CLK);
        if (ld_en[k]) begin
            ld_en[k] = 1'b0;
            mdl_wr(k, la, ldd);
        end
        checks++;
        if (rsp_valid[k] !== 1'b0) begin
            errors++;
            $display("FAIL rd_pulse_width k=%0d got %b exp 0", k, rsp_valid[k]);
        end
    endtask

    task automatic test_reset;
        repeat (2) begin
            @(negedge CLK);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (req_ready[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_ready k=%0d got %b exp 0", k, req_ready[k]);
                end
                checks++;
                if (rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_rsp k=%0d got valid=%b data=%h exp valid=0 data=00", k, rsp_valid[k], rsp_rdata[k]);
                end
            end
        end
        RST = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (req_ready[k] !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_ready k=%0d got %b exp 1", k, req_ready[k]);
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_preload;
        for (int unsigned a = 0; a < 256; a++) begin
            for (int k = 0; k < 2; k++) begin
                ld_en[k] = 1'b1; ld_addr[k] = 8'(a); ld_data[k] = 8'($urandom);
                mdl_wr(k, 8'(a), ld_data[k]);
            end
            @(negedge CLK);
        end
        ld_en = '0;
    endtask

    task automatic test_load_fetch;
        ld(0, 8'h00, 8'h04);
        ld(0, 8'h01, 8'h1F);
        rd(0, 8'h00, 1'b0, 8'h00, 8'h00);
        rd(0, 8'h01, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_latency;
        time t;
        wr(1, 8'h10, 8'hA5, t);
        rd(1, 8'h10, 1'b1, 8'h10, 8'h00);
        rd(1, 8'h10, 1'b0, 8'h00, 8'h00);
        rd(0, 8'h00, 1'b1, 8'h00, 8'h77);
        rd(0, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_back_to_back;
        time t_first;
        time t_last;
        int  span;
        for (int unsigned i = 0; i < 4; i++) begin
            wr(0, 8'(8'h20 + i), 8'(i + 1), t_last);
            if (i == 0) t_first = t_last;
        end
        span = int'((t_last - t_first) / 10);
        checks++;
`ifdef UNIBUS_MEM_WRITE_ACK_EN
        if (span != 6) begin
`else
        if (span != 3) begin
`endif
            errors++;
            $display("FAIL b2b_span got %0d cycles", span);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            rd(0, 8'(8'h20 + i), 1'b0, 8'h00, 8'h00);
        end
    endtask

    task automatic test_boundary;
        time t;
        wr(1, 8'h80, 8'hFF, t);
        rd(1, 8'h80, 1'b0, 8'h00, 8'h00);
        rd(1, 8'h7F, 1'b0, 8'h00, 8'h00);
        ld(1, 8'hC0, 8'h5A);
        rd(1, 8'hC0, 1'b0, 8'h00, 8'h00);
        // loader strobe together with a read request: no accept
        ld_en[0] = 1'b1; ld_addr[0] = 8'h30; ld_data[0] = 8'h6B;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 8'h31;
        #1;
        checks++;
        if (req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL ld_blocks_ready got %b exp 0", req_ready[0]);
        end
        @(negedge CLK);
        mdl_wr(0, 8'h30, 8'h6B);
        ld_en[0] = 1'b0;
        req_valid[0] = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL ld_blocks_accept got rsp_valid=%b exp 0", rsp_valid[0]);
        end
        rd(0, 8'h30, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid_read;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 8'h10;
        #1;
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready got %b exp 1", req_ready[1]);
        end
        @(negedge CLK);
        req_valid[1] = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid[1] !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_rsp cycle=%0d got %b exp 0", i, rsp_valid[1]);
            end
            @(negedge CLK);
        end
        rd(1, 8'h10, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_write_ack;
        time t;
        wr(0, 8'h05, 8'h3C, t);
        rd(0, 8'h05, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_random;
        time t;
        int  k;
        for (int i = 0; i < 80; i++) begin
            k = int'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: wr(k, 8'($urandom), 8'($urandom), t);
                1: ld(k, 8'($urandom), 8'($urandom));
                default: rd(k, 8'($urandom), ($urandom_range(0, 3) == 0),
                            8'($urandom), 8'($urandom));
            endcase
        end
    endtask

    initial begin
        test_reset;
        test_preload;
        test_load_fetch;
        test_latency;
        test_back_to_back;
        test_boundary;
        test_reset_mid_read;
        test_write_ack;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/unibus_mem_responder.md
Name: unibus_mem_responder

Overview:
- Byte-wide memory responder for the AY8 memory interface: the target end of the fetch/decode_exec memory requests, serving instruction fetches and data reads/writes.
- Request/response handshake with fixed, parameterized read latency; single-cycle writes.
- Side-band loader port preloads program images before or between core activity.
- Sits between the core's memory-interface signals and a synthesized byte array.

Parameters:
- ADDR_W, 8, request/loader address width.
- DATA_W, 8, data width.
- DEPTH, 256, implemented words; must be <= 2**ADDR_W.
- RD_LATENCY, 1, edges from read accept to the edge at which rsp_valid is sampled high; legal 1..15.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  1  initiator presents a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  responder can accept; handshake completes when req_valid && req_ready at a rising edge.
- rsp_valid  out  1  read data valid; one-cycle pulse, no backpressure.
- rsp_rdata  out  DATA_W  read data; meaningful only while rsp_valid is high.
- ld_en  in  1  loader write strobe.
- ld_addr  in  ADDR_W  loader address.
- ld_data  in  DATA_W  loader data.

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Reset: state IDLE, latency counter 0, rsp_valid 0, rsp_rdata 0, read-holding register 0.
  - req_ready is 0 while RST is high.
  - Memory contents are not cleared.
- RST high mid-read: the pending read is dropped and no rsp_valid is produced.
- FSM states and transitions:
  - IDLE to RESP on an accepted read when RD_LATENCY = 1.
  - IDLE to WAIT on an accepted read when RD_LATENCY > 1; cnt loads RD_LATENCY-2.
  - WAIT decrements cnt; WAIT to RESP when cnt == 0.
  - RESP to IDLE unconditionally.
- req_ready = (state == IDLE) && !ld_en && !RST, combinational.
- Read accept:
  - The array word at req_addr is captured into the holding register at the accept edge.
  - rsp_rdata reflects the data at accept time, immune to later writes or loads.
  - rsp_valid is high only in RESP, sampled high at the RD_LATENCY-th edge after the accept edge.
  - Read throughput: one per RD_LATENCY+1 cycles.
- Write accept:
  - Array updated at the accept edge; state stays IDLE, req_ready stays 1.
  - Back-to-back writes are allowed every cycle.
  - No response is generated (see optional feature).
- Loader:
  - ld_en writes ld_data to ld_addr at the edge in any state, including WAIT and RESP.
  - ld_en forces req_ready = 0, so a loader write and a request accept never coincide.
- Out-of-range address (addr >= DEPTH):
  - Reads return all-zero with normal timing.
  - Writes and loader writes are silently dropped.
- Same-cycle read after write to the same address: not possible, because a write completes at its accept edge; the next read sees the new value.
- req_valid while req_ready = 0: ignored.
  - The initiator holds the request; no request state is captured.

Optional Feature:
- Macro: UNIBUS_MEM_WRITE_ACK_EN.
- Defined:
  - An accepted write also goes IDLE to RESP (ignoring RD_LATENCY); rsp_valid pulses one cycle, with rsp_rdata = the written data.
  - req_ready is 0 during that RESP, so writes sustain one per 2 cycles.
- Undefined: behaviour as above; writes produce no response.

Test Plan:
- Reset/idle: hold RST 2 cycles, then release -> rsp_valid=0 and rsp_rdata=8'h00; req_ready=0 while RST high, 1 on the first cycle after.
- Load-then-fetch (RD_LATENCY=1): ld 8'h00 <- 8'h04 and 8'h01 <- 8'h1F; read addr 8'h00 at edge E -> rsp_valid=1 and rsp_rdata=8'h04 sampled at E+1; req_ready=0 in that cycle; read 8'h01 accepted at E+2 -> rsp_rdata=8'h1F at E+3.
- Latency (RD_LATENCY=3): write 8'h10 <- 8'hA5, then read 8'h10 accepted at E -> rsp_valid sampled high only at E+3; a loader write 8'h10 <- 8'h00 at E+1 still yields 8'hA5.
- Back-to-back writes: write addrs 8'h20..8'h23 on 4 consecutive cycles with data 8'h01..8'h04 -> all accepted; reads return 8'h01..8'h04.
- Boundary (DEPTH=128): write 8'h80 <- 8'hFF, then read 8'h80 -> 8'h00; read 8'h7F returns its prior value; ld_en high during a req_valid -> req_ready=0 and no accept.
- Reset mid-read plus macro: assert RST in WAIT -> no rsp_valid; next read succeeds. With UNIBUS_MEM_WRITE_ACK_EN, write 8'h05 <- 8'h3C -> rsp_valid=1 and rsp_rdata=8'h3C the next cycle.
